// File: rtl/calculator_pkg.sv
// Shared widths and FSM state encoding for the calculator datapath controller.
package calculator_pkg;

    localparam int DATA_W        = 32;
    localparam int MEM_WORD_SIZE = 64;
    localparam int ADDR_W        = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_ADD,
        S_WRITE,
        S_END
    } state_t;

endpackage

// File: rtl/calc_controller_if.sv
// Host/SRAM/adder/buffer signal bundle for calc_controller.
// The slave modport is the controller's view; master is the surrounding system.
interface calc_controller_if;
    import calculator_pkg::*;

    logic                     start_i;
    logic [ADDR_W-1:0]        read_start_addr_i;
    logic [ADDR_W-1:0]        read_end_addr_i;
    logic [ADDR_W-1:0]        write_start_addr_i;
    logic                     read_en_o;
    logic [ADDR_W-1:0]        read_addr_o;
    logic [MEM_WORD_SIZE-1:0] rdata_i;
    logic [DATA_W-1:0]        op_a_o;
    logic [DATA_W-1:0]        op_b_o;
    logic                     loc_sel_o;
    logic [MEM_WORD_SIZE-1:0] buffer_i;
    logic                     write_en_o;
    logic [ADDR_W-1:0]        write_addr_o;
    logic [MEM_WORD_SIZE-1:0] write_data_o;
    logic                     busy_o;
    logic                     done_o;
    logic                     err_o;

    modport slave (
        input  start_i, read_start_addr_i, read_end_addr_i, write_start_addr_i,
        input  rdata_i, buffer_i,
        output read_en_o, read_addr_o, op_a_o, op_b_o, loc_sel_o,
        output write_en_o, write_addr_o, write_data_o, busy_o, done_o, err_o
    );

    modport master (
        output start_i, read_start_addr_i, read_end_addr_i, write_start_addr_i,
        output rdata_i, buffer_i,
        input  read_en_o, read_addr_o, op_a_o, op_b_o, loc_sel_o,
        input  write_en_o, write_addr_o, write_data_o, busy_o, done_o, err_o
    );

endinterface

// File: rtl/calc_controller.sv
// Sequencer: reads operand word pairs, feeds the adder, writes paired results back.
// Optional busy-cycle counter enabled with `define CALC_CTRL_PERF_EN.
module calc_controller
    import calculator_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    calc_controller_if.slave   bus
`ifdef CALC_CTRL_PERF_EN
    ,
    output logic [31:0]        cycle_count_o
`endif
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   r_ptr_q, r_ptr_d;
    logic [ADDR_W-1:0]   w_ptr_q, w_ptr_d;
    logic                loc_sel_q, loc_sel_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   span;
    logic                range_bad;
    logic                start_ok;

    // An even word count means end - start is odd.
    assign span      = bus.read_end_addr_i - bus.read_start_addr_i;
    assign range_bad = (bus.read_end_addr_i < bus.read_start_addr_i) || !span[0];
    assign start_ok  = (state_q == S_IDLE) && bus.start_i && !range_bad;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            r_ptr_q   <= '0;
            w_ptr_q   <= '0;
            loc_sel_q <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_ptr_q   <= r_ptr_d;
            w_ptr_q   <= w_ptr_d;
            loc_sel_q <= loc_sel_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        r_ptr_d   = r_ptr_q;
        w_ptr_d   = w_ptr_q;
        loc_sel_d = loc_sel_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    if (range_bad) begin
                        err_d = 1'b1;
                    end else begin
                        r_ptr_d   = bus.read_start_addr_i;
                        w_ptr_d   = bus.write_start_addr_i;
                        loc_sel_d = 1'b0;
                        state_d   = S_READ;
                    end
                end
            end
            S_READ: state_d = S_WAIT;
            S_WAIT: begin
                op_a_d  = bus.rdata_i[DATA_W-1:0];
                op_b_d  = bus.rdata_i[MEM_WORD_SIZE-1:DATA_W];
                state_d = S_ADD;
            end
            // The buffer captures into half loc_sel_q on this edge, so flip afterwards.
            S_ADD: begin
                loc_sel_d = ~loc_sel_q;
                if (!loc_sel_q) begin
                    r_ptr_d = r_ptr_q + ADDR_ONE;
                    state_d = S_READ;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                w_ptr_d = w_ptr_q + ADDR_ONE;
                if (r_ptr_q == bus.read_end_addr_i) begin
                    state_d = S_END;
                end else begin
                    r_ptr_d = r_ptr_q + ADDR_ONE;
                    state_d = S_READ;
                end
            end
            S_END:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.read_en_o    = (state_q == S_READ);
        bus.read_addr_o  = r_ptr_q;
        bus.op_a_o       = op_a_q;
        bus.op_b_o       = op_b_q;
        bus.loc_sel_o    = loc_sel_q;
        bus.write_en_o   = (state_q == S_WRITE);
        bus.write_addr_o = w_ptr_q;
        bus.write_data_o = bus.buffer_i;
        bus.busy_o       = (state_q != S_IDLE);
        bus.done_o       = (state_q == S_END);
        bus.err_o        = err_q;
    end

`ifdef CALC_CTRL_PERF_EN
    logic [31:0] cycle_count_q, cycle_count_d;

    // Saturating busy-cycle count, restarted by each accepted start and held while idle.
    always_comb begin
        cycle_count_d = cycle_count_q;
        if (start_ok) begin
            cycle_count_d = '0;
        end else if ((state_q != S_IDLE) && (cycle_count_q != '1)) begin
            cycle_count_d = cycle_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cycle_count_q <= '0;
        end else begin
            cycle_count_q <= cycle_count_d;
        end
    end

    assign cycle_count_o = cycle_count_q;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_calc_controller.sv
// Self-checking bench for calc_controller: SRAM, adder and result buffer models plus a
// scoreboard of expected read addresses and write transactions.
module tb_calc_controller;
    import calculator_pkg::*;

    typedef struct {
        logic [ADDR_W-1:0] rdStart;
        logic [ADDR_W-1:0] rdEnd;
        logic [ADDR_W-1:0] wrStart;
        bit                expectErr;
    } vector_t;

    typedef struct {
        logic [ADDR_W-1:0]        addr;
        logic [MEM_WORD_SIZE-1:0] data;
    } write_t;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [MEM_WORD_SIZE-1:0] mem [0:(1<<ADDR_W)-1];
    logic [MEM_WORD_SIZE-1:0] rdata = '0;
    logic [MEM_WORD_SIZE-1:0] buffer = 64'h0123_4567_89AB_CDEF;
    logic [DATA_W-1:0]        sum;

    logic [ADDR_W-1:0] readQ [$];
    write_t            writeQ [$];
    int                checks = 0;
    int                errors = 0;
    int                errPulses = 0;
    int                donePulses = 0;
    int                perfHold = 0;
    vector_t           vectors [6];

    calc_controller_if calcIf ();

`ifdef CALC_CTRL_PERF_EN
    logic [31:0] cycleCount;
`endif

    calc_controller dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (calcIf)
`ifdef CALC_CTRL_PERF_EN
        ,
        .cycle_count_o (cycleCount)
`endif
    );

    always #5 clk = ~clk;

    // SRAM read port, adder and half-selectable result buffer
    assign sum = calcIf.op_a_o + calcIf.op_b_o;
    assign calcIf.rdata_i  = rdata;
    assign calcIf.buffer_i = buffer;

    always @(posedge clk) begin
        if (calcIf.read_en_o) rdata <= mem[calcIf.read_addr_o];
        if (calcIf.loc_sel_o) buffer[63:32] <= sum;
        else                  buffer[31:0]  <= sum;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic reportUnexpected(input string name, input logic [63:0] actual);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got %0h, expected no transaction", name, actual);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (calcIf.read_en_o) begin
                if (readQ.size() == 0) reportUnexpected("unexpected_read", 64'(calcIf.read_addr_o));
                else checkOutput("read_addr", 64'(calcIf.read_addr_o), 64'(readQ.pop_front()));
            end
            if (calcIf.write_en_o) begin
                if (writeQ.size() == 0) begin
                    reportUnexpected("unexpected_write", 64'(calcIf.write_addr_o));
                end else begin
                    write_t exp;
                    exp = writeQ.pop_front();
                    checkOutput("write_addr", 64'(calcIf.write_addr_o), 64'(exp.addr));
                    checkOutput("write_data", calcIf.write_data_o, exp.data);
                end
            end
            if (calcIf.err_o)  errPulses++;
            if (calcIf.done_o) donePulses++;
        end
    end

    task automatic pushExpected(input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] re,
                                input logic [ADDR_W-1:0] ws);
        int n;
        n = int'(re) - int'(rs) + 1;
        for (int k = 0; k < n / 2; k++) begin
            logic [ADDR_W-1:0]        a0;
            logic [ADDR_W-1:0]        a1;
            logic [MEM_WORD_SIZE-1:0] w0;
            logic [MEM_WORD_SIZE-1:0] w1;
            write_t                   wr;
            a0 = rs + ADDR_W'(2 * k);
            a1 = a0 + ADDR_W'(1);
            readQ.push_back(a0);
            readQ.push_back(a1);
            w0 = mem[a0];
            w1 = mem[a1];
            wr.addr = ws + ADDR_W'(k);
            wr.data = {w1[63:32] + w1[31:0], w0[63:32] + w0[31:0]};
            writeQ.push_back(wr);
        end
    endtask

    // Waits for done_o from cycle firstCyc of the run and checks its latency and the aftermath
    task automatic waitDone(input int firstCyc, input int lat);
        int cyc;
        bit seenDone;
        cyc = firstCyc - 1;
        seenDone = 1'b0;
        while (cyc < 200 && !seenDone) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                checkOutput("busy_first_cycle", 64'(calcIf.busy_o), 64'd1);
`ifdef CALC_CTRL_PERF_EN
                checkOutput("perf_cleared", 64'(cycleCount), 64'd0);
`endif
            end
            if (calcIf.done_o) seenDone = 1'b1;
        end
        checkOutput("done_seen", 64'(seenDone), 64'd1);
        checkOutput("done_latency", 64'(cyc), 64'(lat));
        @(negedge clk);
        checkOutput("idle_busy", 64'(calcIf.busy_o), 64'd0);
        checkOutput("done_pulse_len", 64'(calcIf.done_o), 64'd0);
        checkOutput("writes_pending", 64'(writeQ.size()), 64'd0);
        checkOutput("reads_pending", 64'(readQ.size()), 64'd0);
`ifdef CALC_CTRL_PERF_EN
        checkOutput("perf_count", 64'(cycleCount), 64'(lat));
        perfHold = lat;
`endif
    endtask

    task automatic applyStimulus(input vector_t v);
        int n;
        int lat;
        n   = int'(v.rdEnd) - int'(v.rdStart) + 1;
        lat = 3 * n + n / 2 + 1;
        @(posedge clk); #1;
`ifdef CALC_CTRL_PERF_EN
        checkOutput("perf_hold", 64'(cycleCount), 64'(perfHold));
`endif
        calcIf.start_i            = 1'b1;
        calcIf.read_start_addr_i  = v.rdStart;
        calcIf.read_end_addr_i    = v.rdEnd;
        calcIf.write_start_addr_i = v.wrStart;
        if (!v.expectErr) pushExpected(v.rdStart, v.rdEnd, v.wrStart);
        @(posedge clk); #1;
        calcIf.start_i = 1'b0;
        if (v.expectErr) begin
            @(negedge clk);
            checkOutput("err_pulse", 64'(calcIf.err_o), 64'd1);
            checkOutput("err_busy", 64'(calcIf.busy_o), 64'd0);
            @(negedge clk);
            checkOutput("err_one_cycle", 64'(calcIf.err_o), 64'd0);
            checkOutput("err_still_idle", 64'(calcIf.busy_o), 64'd0);
        end else begin
            waitDone(1, lat);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int errBefore;
        int doneBefore;
        vector_t v;

        calcIf.start_i            = 1'b0;
        calcIf.read_start_addr_i  = '0;
        calcIf.read_end_addr_i    = '0;
        calcIf.write_start_addr_i = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = {$urandom, $urandom};
        mem[0] = {32'd2, 32'd1};
        mem[1] = {32'd4, 32'd3};
        mem[2] = {32'hFFFF_FFFF, 32'd2};

        vectors[0] = '{rdStart: 10'd0,  rdEnd: 10'd1,  wrStart: 10'h010, expectErr: 1'b0};
        vectors[1] = '{rdStart: 10'd0,  rdEnd: 10'd3,  wrStart: 10'h010, expectErr: 1'b0};
        vectors[2] = '{rdStart: 10'd5,  rdEnd: 10'd7,  wrStart: 10'h010, expectErr: 1'b1};
        vectors[3] = '{rdStart: 10'd7,  rdEnd: 10'd5,  wrStart: 10'h010, expectErr: 1'b1};
        vectors[4] = '{rdStart: 10'd2,  rdEnd: 10'd2,  wrStart: 10'h010, expectErr: 1'b1};
        vectors[5] = '{rdStart: 10'd8,  rdEnd: 10'd11, wrStart: 10'h3FF, expectErr: 1'b0};

        #1;
        checkOutput("rst_busy", 64'(calcIf.busy_o), 64'd0);
        checkOutput("rst_done", 64'(calcIf.done_o), 64'd0);
        checkOutput("rst_err", 64'(calcIf.err_o), 64'd0);
        checkOutput("rst_read_en", 64'(calcIf.read_en_o), 64'd0);
        checkOutput("rst_write_en", 64'(calcIf.write_en_o), 64'd0);
        checkOutput("rst_loc_sel", 64'(calcIf.loc_sel_o), 64'd0);
        checkOutput("rst_op_a", 64'(calcIf.op_a_o), 64'd0);
        checkOutput("rst_op_b", 64'(calcIf.op_b_o), 64'd0);
        checkOutput("rst_read_addr", 64'(calcIf.read_addr_o), 64'd0);
        checkOutput("rst_write_addr", 64'(calcIf.write_addr_o), 64'd0);
        checkOutput("wdata_passthrough", calcIf.write_data_o, 64'h0123_4567_89AB_CDEF);
`ifdef CALC_CTRL_PERF_EN
        checkOutput("rst_perf", 64'(cycleCount), 64'd0);
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 6; i++) applyStimulus(vectors[i]);

        // A second start pulse during S_ADD must not disturb the running transfer
        errBefore  = errPulses;
        doneBefore = donePulses;
        pushExpected(10'd0, 10'd1, 10'h020);
        @(posedge clk); #1;
        calcIf.start_i            = 1'b1;
        calcIf.read_start_addr_i  = 10'd0;
        calcIf.read_end_addr_i    = 10'd1;
        calcIf.write_start_addr_i = 10'h020;
        @(posedge clk); #1;
        calcIf.start_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        calcIf.start_i = 1'b1;
        @(posedge clk); #1;
        calcIf.start_i = 1'b0;
        waitDone(4, 8);
        checkOutput("busy_start_no_err", 64'(errPulses), 64'(errBefore));
        checkOutput("busy_start_one_done", 64'(donePulses), 64'(doneBefore + 1));

        // Reset during the first S_WRITE of a 4-word run
        pushExpected(10'd0, 10'd3, 10'h030);
        @(posedge clk); #1;
        calcIf.start_i            = 1'b1;
        calcIf.read_start_addr_i  = 10'd0;
        calcIf.read_end_addr_i    = 10'd3;
        calcIf.write_start_addr_i = 10'h030;
        @(posedge clk); #1;
        calcIf.start_i = 1'b0;
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
        checkOutput("mid_write_en", 64'(calcIf.write_en_o), 64'd1);
        checkOutput("mid_write_addr", 64'(calcIf.write_addr_o), 64'h030);
        rst = 1'b1;
        writeQ.delete();
        readQ.delete();
        #1;
        checkOutput("abort_busy", 64'(calcIf.busy_o), 64'd0);
        checkOutput("abort_write_en", 64'(calcIf.write_en_o), 64'd0);
        checkOutput("abort_read_en", 64'(calcIf.read_en_o), 64'd0);
        checkOutput("abort_done", 64'(calcIf.done_o), 64'd0);
        checkOutput("abort_loc_sel", 64'(calcIf.loc_sel_o), 64'd0);
        checkOutput("abort_op_a", 64'(calcIf.op_a_o), 64'd0);
        checkOutput("abort_write_addr", 64'(calcIf.write_addr_o), 64'd0);
        perfHold = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("post_abort_idle", 64'(calcIf.busy_o), 64'd0);

        v = '{rdStart: 10'd0, rdEnd: 10'd3, wrStart: 10'h040, expectErr: 1'b0};
        applyStimulus(v);
        v = '{rdStart: 10'd0, rdEnd: 10'd1, wrStart: 10'h050, expectErr: 1'b0};
        applyStimulus(v);
        repeat (5) @(negedge clk);
`ifdef CALC_CTRL_PERF_EN
        checkOutput("perf_hold_idle", 64'(cycleCount), 64'd8);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
